// File: rtl/spw_pll_sup_pkg.sv
// ---------------------------------------------------------------------------
// spw_pll_sup_pkg
// Shared definitions for the SpaceWire PLL lock supervisor:
//   - sup_state_e : supervisor FSM states
//   - DEF_*       : default parameter values
//   - max3 / cnt_width : helpers used to size the shared cycle counter
// ---------------------------------------------------------------------------
package spw_pll_sup_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } sup_state_e;

   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_RST_PULSE_CYC = 16;
   localparam int DEF_STABLE_CYC    = 1024;
   localparam int DEF_TIMEOUT_CYC   = 65536;
   localparam int DEF_MAX_RETRY     = 3;
   localparam int DEF_CNT_W         = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Bits needed to hold values 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/spw_pll_lock_supervisor_sync.sv
// ---------------------------------------------------------------------------
// spw_sync_bit
// N-stage single-bit synchronizer with synchronous active-low reset.
// Ports:
//   clk      in  destination clock
//   rst_n    in  synchronous active-low reset (clears every stage)
//   async_in in  asynchronous input bit
//   sync_out out input after STAGES flops
// ---------------------------------------------------------------------------
module spw_sync_bit
   import spw_pll_sup_pkg::*;
#(
   parameter int STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the raw input into the chain, oldest sample at the top bit.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], async_in};
   end

   // Synchronizer chain register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= {STAGES{1'b0}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/spw_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// spw_pll_lock_supervisor
// Sequences the 50->200 MHz PLL reset, debounces its locked indication and
// releases the SpaceWire core reset only after a stable lock. Runs entirely
// in the free-running reference clock domain.
// Ports:
//   clk           in   50 MHz reference clock
//   rst_n         in   synchronous active-low reset
//   pll_locked    in   asynchronous PLL locked output
//   relock_req    in   pulse: restart the PLL reset sequence
//   err_clr       in   pulse: clear timeout_err and lock_loss_cnt
//   pll_rst       out  registered PLL reset, active high
//   core_rst_n    out  registered active-low core reset
//   lock_ok       out  high only while in RUN
//   timeout_err   out  sticky, set on entry to FAIL
//   lock_loss_cnt out  saturating count of lock losses seen in RUN
// ---------------------------------------------------------------------------
module spw_pll_lock_supervisor
   import spw_pll_sup_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int RST_PULSE_CYC = DEF_RST_PULSE_CYC,
   parameter int STABLE_CYC    = DEF_STABLE_CYC,
   parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC,
   parameter int MAX_RETRY     = DEF_MAX_RETRY,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pll_locked,
   input  logic             relock_req,
   input  logic             err_clr,
   output logic             pll_rst,
   output logic             core_rst_n,
   output logic             lock_ok,
   output logic             timeout_err,
   output logic [CNT_W-1:0] lock_loss_cnt
);

   localparam int CW = cnt_width(max3(TIMEOUT_CYC, STABLE_CYC, RST_PULSE_CYC));
   localparam int RW = cnt_width(MAX_RETRY);

   localparam logic [CW-1:0]    RST_LAST    = CW'(RST_PULSE_CYC - 1);
   localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYC - 1);
   localparam logic [CW-1:0]    TO_LAST     = CW'(TIMEOUT_CYC - 1);
   localparam logic [RW-1:0]    RETRY_MAX   = RW'(MAX_RETRY);
   localparam logic [CNT_W-1:0] LOSS_MAX    = {CNT_W{1'b1}};

   logic             locked_s;
   sup_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [RW-1:0]    retry_q, retry_d;
   logic [RW-1:0]    retry_inc;
   logic             loss_evt;
   logic             pll_rst_q, pll_rst_d;
   logic             core_rst_n_q, core_rst_n_d;
   logic             lock_ok_q, lock_ok_d;
   logic             timeout_err_q, timeout_err_d;
   logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;

   spw_sync_bit #(
      .STAGES(SYNC_STAGES)
   ) u_lock_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_in(pll_locked),
      .sync_out(locked_s)
   );

   assign retry_inc = retry_q + RW'(1);

   // Next-state logic; the shared counter restarts on every state change.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CW'(1);
      retry_d  = retry_q;
      loss_evt = 1'b0;
      case (state_q)
         PLL_RST: begin
            if (relock_req) begin
               cnt_d = {CW{1'b0}};
            end else if (cnt_q == RST_LAST) begin
               state_d = WAIT_LOCK;
               cnt_d   = {CW{1'b0}};
            end else begin
               state_d = PLL_RST;
            end
         end
         WAIT_LOCK: begin
            if (relock_req) begin
               state_d = PLL_RST;
               cnt_d   = {CW{1'b0}};
            end else if (locked_s) begin
               // Lock also wins on the timeout cycle.
               state_d = STABLE;
               cnt_d   = {CW{1'b0}};
            end else if (cnt_q == TO_LAST) begin
               retry_d = retry_inc;
               state_d = (retry_inc == RETRY_MAX) ? FAIL : PLL_RST;
               cnt_d   = {CW{1'b0}};
            end else begin
               state_d = WAIT_LOCK;
            end
         end
         STABLE: begin
            if (relock_req) begin
               state_d = PLL_RST;
               cnt_d   = {CW{1'b0}};
            end else if (!locked_s) begin
               // Glitch before release: new timeout window, no loss counted.
               state_d = WAIT_LOCK;
               cnt_d   = {CW{1'b0}};
            end else if (cnt_q == STABLE_LAST) begin
               state_d = RUN;
               retry_d = {RW{1'b0}};
               cnt_d   = {CW{1'b0}};
            end else begin
               state_d = STABLE;
            end
         end
         RUN: begin
            cnt_d = {CW{1'b0}};
            if (!locked_s) begin
               // Loss takes priority over a simultaneous relock request.
               state_d  = PLL_RST;
               loss_evt = 1'b1;
            end else if (relock_req) begin
               state_d = PLL_RST;
            end else begin
               state_d = RUN;
            end
         end
         FAIL: begin
            cnt_d = {CW{1'b0}};
            if (relock_req) begin
               state_d = PLL_RST;
               retry_d = {RW{1'b0}};
            end else begin
               state_d = FAIL;
            end
         end
         default: begin
            state_d = PLL_RST;
            cnt_d   = {CW{1'b0}};
            retry_d = {RW{1'b0}};
         end
      endcase
   end

   // Output decode from the next state so every output is a flop.
   always_comb begin
      pll_rst_d    = (state_d == PLL_RST) || (state_d == FAIL);
      core_rst_n_d = (state_d == RUN);
      lock_ok_d    = (state_d == RUN);

      // Entering FAIL beats a same-cycle clear.
      if ((state_d == FAIL) && (state_q != FAIL)) begin
         timeout_err_d = 1'b1;
      end else if (err_clr) begin
         timeout_err_d = 1'b0;
      end else begin
         timeout_err_d = timeout_err_q;
      end

      // A loss coincident with a clear leaves exactly one loss recorded.
      if (loss_evt) begin
         if (err_clr) begin
            loss_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
         end else if (loss_cnt_q == LOSS_MAX) begin
            loss_cnt_d = loss_cnt_q;
         end else begin
            loss_cnt_d = loss_cnt_q + CNT_W'(1);
         end
      end else if (err_clr) begin
         loss_cnt_d = {CNT_W{1'b0}};
      end else begin
         loss_cnt_d = loss_cnt_q;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= PLL_RST;
         cnt_q         <= {CW{1'b0}};
         retry_q       <= {RW{1'b0}};
         pll_rst_q     <= 1'b1;
         core_rst_n_q  <= 1'b0;
         lock_ok_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         loss_cnt_q    <= {CNT_W{1'b0}};
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         retry_q       <= retry_d;
         pll_rst_q     <= pll_rst_d;
         core_rst_n_q  <= core_rst_n_d;
         lock_ok_q     <= lock_ok_d;
         timeout_err_q <= timeout_err_d;
         loss_cnt_q    <= loss_cnt_d;
      end
   end

   assign pll_rst       = pll_rst_q;
   assign core_rst_n    = core_rst_n_q;
   assign lock_ok       = lock_ok_q;
   assign timeout_err   = timeout_err_q;
   assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_spw_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_spw_pll_lock_supervisor
// Directed stimulus; every expected change of the output vector
// {pll_rst, core_rst_n, lock_ok, timeout_err, lock_loss_cnt} is queued with
// the clock edge at which it must appear. A separate monitor pops an entry
// whenever the outputs change and compares edge number and value.
// Edge k happens at time 10k-5; inputs set "at cycle c" are first sampled
// by edge c+1.
// ---------------------------------------------------------------------------
module tb_spw_pll_lock_supervisor;

   typedef struct {
      int         cyc;
      logic [5:0] val;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       pll_locked;
   logic       relock_req;
   logic       err_clr;
   logic       pll_rst;
   logic       core_rst_n;
   logic       lock_ok;
   logic       timeout_err;
   logic [1:0] lock_loss_cnt;

   exp_t exp_q[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   spw_pll_lock_supervisor #(
      .SYNC_STAGES  (2),
      .RST_PULSE_CYC(4),
      .STABLE_CYC   (8),
      .TIMEOUT_CYC  (32),
      .MAX_RETRY    (2),
      .CNT_W        (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pll_locked   (pll_locked),
      .relock_req   (relock_req),
      .err_clr      (err_clr),
      .pll_rst      (pll_rst),
      .core_rst_n   (core_rst_n),
      .lock_ok      (lock_ok),
      .timeout_err  (timeout_err),
      .lock_loss_cnt(lock_loss_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [5:0] ov(input logic pr, input logic cr, input logic lk,
                                     input logic te, input logic [1:0] c);
      return {pr, cr, lk, te, c};
   endfunction

   task automatic push(input int c, input logic [5:0] v);
      exp_t e;
      e.cyc = c;
      e.val = v;
      exp_q.push_back(e);
   endtask

   // Advance to just after edge c.
   task automatic at(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: compares on every output change, flags events that never came.
   initial begin : monitor
      logic [5:0] cur;
      logic [5:0] prev;
      exp_t       e;
      prev = 6'bxxxxxx;
      forever begin
         @(negedge clk);
         cur = {pll_rst, core_rst_n, lock_ok, timeout_err, lock_loss_cnt};
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_event: at edge %0d outputs=%b, required %b at edge %0d",
                     cyc, cur, e.val, e.cyc);
         end
         if (cur !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_change: edge %0d outputs %b -> %b, none required",
                        cyc, prev, cur);
            end else begin
               e = exp_q.pop_front();
               if ((e.cyc != cyc) || (e.val !== cur)) begin
                  failures++;
                  $display("FAIL output_event: got %b at edge %0d, required %b at edge %0d",
                           cur, cyc, e.val, e.cyc);
               end
            end
         end
         prev = cur;
      end
   end

   initial begin : stimulus
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      relock_req = 1'b0;
      err_clr    = 1'b0;

      // Reset state, then 4-cycle PLL reset pulse after release.
      push(1, ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
      at(3);   rst_n = 1'b1;
      push(7, ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));

      // Nominal lock: first edge sampling locked is 18, release at 28.
      at(17);  pll_locked = 1'b1;
      push(28, ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd0));

      // Loss 1 in RUN, then relock with a one-cycle glitch in STABLE.
      at(32);  pll_locked = 1'b0;
      push(35, ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd1));
      push(39, ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
      at(40);  pll_locked = 1'b1;
      at(45);  pll_locked = 1'b0;
      at(46);  pll_locked = 1'b1;
      push(57, ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd1));

      // Loss 2.
      at(60);  pll_locked = 1'b0;
      push(63, ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd2));
      push(67, ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd2));
      at(67);  pll_locked = 1'b1;
      push(78, ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd2));

      // Loss 3 with err_clr in the same cycle: count becomes 1.
      at(80);  pll_locked = 1'b0;
      at(82);  err_clr = 1'b1;
      push(83, ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd1));
      at(83);  err_clr = 1'b0;
      push(87, ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
      at(87);  pll_locked = 1'b1;
      push(98, ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd1));

      // Losses 4..6: count goes 2, 3, then stays saturated at 3.
      for (int k = 0; k < 3; k++) begin
         logic [1:0] n;
         int         b;
         b = 100 + 20 * k;
         n = (k == 0) ? 2'd2 : 2'd3;
         at(b);      pll_locked = 1'b0;
         push(b + 3,  ov(1'b1, 1'b0, 1'b0, 1'b0, n));
         push(b + 7,  ov(1'b0, 1'b0, 1'b0, 1'b0, n));
         at(b + 7);  pll_locked = 1'b1;
         push(b + 18, ov(1'b0, 1'b1, 1'b1, 1'b0, n));
      end

      // relock_req in RUN with steady lock: no count increment.
      at(160); relock_req = 1'b1;
      push(161, ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd3));
      at(161); relock_req = 1'b0;
      push(165, ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd3));
      push(174, ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd3));

      // Timeout path: two 32-cycle windows then FAIL.
      at(176); pll_locked = 1'b0;
      push(179, ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd3));
      push(183, ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd3));
      push(215, ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd3));
      push(219, ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd3));
      push(251, ov(1'b1, 1'b0, 1'b0, 1'b1, 2'd3));

      // err_clr in FAIL clears flags but the PLL stays held.
      at(260); err_clr = 1'b1;
      push(261, ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
      at(261); err_clr = 1'b0;

      // relock_req leaves FAIL with retry cleared: two full windows again.
      at(270); relock_req = 1'b1;
      at(271); relock_req = 1'b0;
      push(275, ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
      push(307, ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
      push(311, ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
      // err_clr coincident with FAIL entry: the error flag still sets.
      at(342); err_clr = 1'b1;
      push(343, ov(1'b1, 1'b0, 1'b0, 1'b1, 2'd0));
      at(343); err_clr = 1'b0;

      // Recover from FAIL into RUN.
      at(350); relock_req = 1'b1;
      at(351); relock_req = 1'b0;
      push(355, ov(1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
      at(355); pll_locked = 1'b1;
      push(366, ov(1'b0, 1'b1, 1'b1, 1'b1, 2'd0));

      // Reset during RUN, then during STABLE.
      at(370); rst_n = 1'b0;
      push(371, ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
      at(372); rst_n = 1'b1;
      push(376, ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
      at(380); rst_n = 1'b0;
      push(381, ov(1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
      at(381); rst_n = 1'b1;
      push(385, ov(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
      push(394, ov(1'b0, 1'b1, 1'b1, 1'b0, 2'd0));

      at(400);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending_events: %0d still queued, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
